// File: rtl/csr_trap_ctrl_if.sv
// CSR register-file port: the trap sequencer is the master, the CSR file the slave.
// Read data is combinational and valid in the same cycle as csr_rd.
interface csr_trap_ctrl_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rd;
  logic        csr_wr;
  logic [31:0] csr_rdata;

  modport master (
    output csr_addr, csr_wdata, csr_rd, csr_wr,
    input  csr_rdata
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_rd, csr_wr,
    output csr_rdata
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer driving the CSR port while trap_busy is high.
// Interrupt entry saves mepc/mcause, updates mstatus and vectors through mtvec.
module csr_trap_ctrl #(
  parameter int MIE_BIT  = 3,
  parameter int MPIE_BIT = 7,
  parameter int MEIE_BIT = 11,
  parameter int MTIE_BIT = 7,
  parameter int HOLDOFF  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               irq_ext_i,
  input  logic               irq_tmr_i,
  input  logic               mret_req_i,
  input  logic [31:0]        pc_cur_i,
  csr_trap_ctrl_if.master    csr,
  output logic               trap_busy_o,
  output logic               pc_redirect_valid_o,
  output logic [31:0]        pc_redirect_o
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [3:0] {
    IDLE, T_CHK_ST, T_CHK_IE, T_EPC, T_CAUSE, T_STAT, T_VEC,
    M_ST, M_STW, M_EPC, REDIR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   st_q, st_d;
  logic [31:0]   epc_q, epc_d;
  logic [31:0]   target_q, target_d;
  logic [3:0]    cause_q, cause_d;
  logic [HW-1:0] holdoff_q, holdoff_d;

  logic          take_irq;
  logic [31:0]   rd_base;
  logic [31:0]   st_trap;
  logic [31:0]   st_mret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      epc_q     <= '0;
      target_q  <= '0;
      cause_q   <= '0;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      epc_q     <= epc_d;
      target_q  <= target_d;
      cause_q   <= cause_d;
      holdoff_q <= holdoff_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    epc_d     = epc_q;
    target_d  = target_q;
    cause_d   = cause_q;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - HW'(1) : holdoff_q;

    csr.csr_addr  = '0;
    csr.csr_wdata = '0;
    csr.csr_rd    = 1'b0;
    csr.csr_wr    = 1'b0;

    take_irq = st_q[MIE_BIT] & ((irq_ext_i & csr.csr_rdata[MEIE_BIT]) |
                                (irq_tmr_i & csr.csr_rdata[MTIE_BIT]));
    rd_base  = {csr.csr_rdata[31:2], 2'b00};

    st_trap           = st_q;
    st_trap[MPIE_BIT] = st_q[MIE_BIT];
    st_trap[MIE_BIT]  = 1'b0;
    st_mret           = st_q;
    st_mret[MIE_BIT]  = st_q[MPIE_BIT];
    st_mret[MPIE_BIT] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (mret_req_i) begin
          state_d = M_ST;
          epc_d   = pc_cur_i;
        end else if ((irq_ext_i | irq_tmr_i) && holdoff_q == '0) begin
          state_d = T_CHK_ST;
          epc_d   = pc_cur_i;
        end
      end
      T_CHK_ST: begin
        csr.csr_addr = 12'h300;
        csr.csr_rd   = 1'b1;
        st_d         = csr.csr_rdata;
        state_d      = T_CHK_IE;
      end
      T_CHK_IE: begin
        csr.csr_addr = 12'h304;
        csr.csr_rd   = 1'b1;
        if (take_irq) begin
          cause_d = (irq_ext_i & csr.csr_rdata[MEIE_BIT]) ? 4'(MEIE_BIT) : 4'(MTIE_BIT);
          state_d = T_EPC;
        end else begin
          // The declining cycle counts as the first holdoff cycle.
          holdoff_d = HW'(HOLDOFF - 1);
          state_d   = IDLE;
        end
      end
      T_EPC: begin
        csr.csr_addr  = 12'h341;
        csr.csr_wr    = 1'b1;
        csr.csr_wdata = epc_q;
        state_d       = T_CAUSE;
      end
      T_CAUSE: begin
        csr.csr_addr  = 12'h342;
        csr.csr_wr    = 1'b1;
        csr.csr_wdata = {1'b1, 27'b0, cause_q};
        state_d       = T_STAT;
      end
      T_STAT: begin
        csr.csr_addr  = 12'h300;
        csr.csr_wr    = 1'b1;
        csr.csr_wdata = st_trap;
        state_d       = T_VEC;
      end
      T_VEC: begin
        csr.csr_addr = 12'h305;
        csr.csr_rd   = 1'b1;
        // Only mode 1 vectors; the reserved modes fall back to direct.
        target_d = (csr.csr_rdata[1:0] == 2'b01) ? rd_base + {26'b0, cause_q, 2'b00} : rd_base;
        state_d  = REDIR;
      end
      M_ST: begin
        csr.csr_addr = 12'h300;
        csr.csr_rd   = 1'b1;
        st_d         = csr.csr_rdata;
        state_d      = M_STW;
      end
      M_STW: begin
        csr.csr_addr  = 12'h300;
        csr.csr_wr    = 1'b1;
        csr.csr_wdata = st_mret;
        state_d       = M_EPC;
      end
      M_EPC: begin
        csr.csr_addr = 12'h341;
        csr.csr_rd   = 1'b1;
        target_d     = rd_base;
        state_d      = REDIR;
      end
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign trap_busy_o         = (state_q != IDLE);
  assign pc_redirect_valid_o = (state_q == REDIR);
  assign pc_redirect_o       = target_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small CSR file model on the slave side.
// Each step prints its transaction; checks are immediate assertions.
module tb_csr_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        irq_ext, irq_tmr, mret_req;
  logic [31:0] pc_cur;
  logic        trap_busy, pc_redirect_valid;
  logic [31:0] pc_redirect;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  csr_trap_ctrl_if bus ();

  csr_trap_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .irq_ext_i           (irq_ext),
    .irq_tmr_i           (irq_tmr),
    .mret_req_i          (mret_req),
    .pc_cur_i            (pc_cur),
    .csr                 (bus),
    .trap_busy_o         (trap_busy),
    .pc_redirect_valid_o (pc_redirect_valid),
    .pc_redirect_o       (pc_redirect)
  );

  always #5 clk = ~clk;

  // CSR file model; the bench pokes setup values through the same write port.
  logic [31:0] mstatus_m = '0, mie_m = '0, mtvec_m = '0, mepc_m = '0, mcause_m = '0;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic        we_m;
  logic [11:0] wa_m;
  logic [31:0] wd_m;

  assign we_m = bus.csr_wr | poke_en;
  assign wa_m = bus.csr_wr ? bus.csr_addr : poke_addr;
  assign wd_m = bus.csr_wr ? bus.csr_wdata : poke_data;

  always @(posedge clk) begin
    if (we_m) begin
      case (wa_m)
        12'h300: mstatus_m <= wd_m;
        12'h304: mie_m     <= wd_m;
        12'h305: mtvec_m   <= wd_m;
        12'h341: mepc_m    <= wd_m;
        12'h342: mcause_m  <= wd_m;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = mstatus_m;
      12'h304: bus.csr_rdata = mie_m;
      12'h305: bus.csr_rdata = mtvec_m;
      12'h341: bus.csr_rdata = mepc_m;
      12'h342: bus.csr_rdata = mcause_m;
      default: bus.csr_rdata = '0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.csr_rd && bus.csr_wr) viol++;
      if (bus.csr_rd && bus.csr_wdata != 0) viol++;
      if (!trap_busy && (bus.csr_rd || bus.csr_wr || bus.csr_addr != 0 || bus.csr_wdata != 0)) viol++;
      if (pc_redirect_valid && !trap_busy) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(posedge clk); #1;
    poke_en   = 1'b0;
  endtask

  // Follows one busy window; lat = edges until busy first seen (0 = never).
  task automatic observe(input bit drop_irq, output int lat, output int busy,
                         output int redir_at, output logic [31:0] redir_pc, output int wmask);
    lat = 0; busy = 0; redir_at = 0; redir_pc = '0; wmask = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (trap_busy) begin
        if (busy == 0) lat = c;
        busy++;
        mret_req = 1'b0;
        if (pc_redirect_valid) begin
          redir_at = busy;
          redir_pc = pc_redirect;
        end
        if (bus.csr_wr) wmask |= (1 << busy);
        if (drop_irq && busy == 3) begin
          irq_ext = 1'b0;
          irq_tmr = 1'b0;
        end
      end else if (busy > 0) begin
        break;
      end
    end
    $display("txn: lat=%0d busy=%0d redir_at=%0d pc=0x%08h wmask=0x%0h", lat, busy, redir_at, redir_pc, wmask);
  endtask

  initial begin
    int lat, busy, rat, wm, act;
    logic [31:0] rpc;

    rst = 1'b1; irq_ext = 1'b0; irq_tmr = 1'b0; mret_req = 1'b0; pc_cur = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(trap_busy), 32'd0);
    chk("rst_valid", 32'(pc_redirect_valid), 32'd0);
    chk("rst_pc", pc_redirect, 32'h0);
    chk("rst_strobes", 32'({bus.csr_rd, bus.csr_wr}), 32'd0);
    chk("rst_addr", 32'(bus.csr_addr), 32'd0);
    @(posedge clk); #1;

    // External interrupt, direct mode
    poke(12'h300, 32'h8); poke(12'h304, 32'h800); poke(12'h305, 32'h100);
    pc_cur = 32'h40; irq_ext = 1'b1;
    observe(1'b1, lat, busy, rat, rpc, wm);
    chk("ext_lat", lat, 1);
    chk("ext_busy", busy, 7);
    chk("ext_redir_at", rat, 7);
    chk("ext_redir_pc", rpc, 32'h100);
    chk("ext_wmask", wm, 32'h38);
    chk("ext_mepc", mepc_m, 32'h40);
    chk("ext_mcause", mcause_m, 32'h8000000B);
    chk("ext_mstatus", mstatus_m, 32'h80);

    // Timer interrupt, vectored mode
    poke(12'h300, 32'h8); poke(12'h304, 32'h80); poke(12'h305, 32'h101);
    pc_cur = 32'h60; irq_tmr = 1'b1;
    observe(1'b1, lat, busy, rat, rpc, wm);
    chk("tmr_busy", busy, 7);
    chk("tmr_redir_pc", rpc, 32'h11C);
    chk("tmr_mepc", mepc_m, 32'h60);
    chk("tmr_mcause", mcause_m, 32'h80000007);

    // Both pending: external wins, vectored offset 11*4
    poke(12'h300, 32'h8); poke(12'h304, 32'h880);
    pc_cur = 32'h64; irq_ext = 1'b1; irq_tmr = 1'b1;
    observe(1'b1, lat, busy, rat, rpc, wm);
    chk("both_mcause", mcause_m, 32'h8000000B);
    chk("both_redir_pc", rpc, 32'h12C);

    // mret with misaligned mepc
    poke(12'h341, 32'h47);
    mret_req = 1'b1;
    observe(1'b0, lat, busy, rat, rpc, wm);
    chk("mret_busy", busy, 4);
    chk("mret_redir_at", rat, 4);
    chk("mret_redir_pc", rpc, 32'h44);
    chk("mret_wmask", wm, 32'h4);
    chk("mret_mstatus", mstatus_m, 32'h88);

    // Declined check and holdoff spacing
    poke(12'h300, 32'h0);
    irq_ext = 1'b1;
    observe(1'b0, lat, busy, rat, rpc, wm);
    chk("dec1_lat", lat, 1);
    chk("dec1_busy", busy, 2);
    chk("dec1_wmask", wm, 0);
    observe(1'b0, lat, busy, rat, rpc, wm);
    chk("dec2_lat", lat, 16);
    chk("dec2_busy", busy, 2);
    chk("dec2_wmask", wm, 0);
    // mret still accepted while holdoff runs
    mret_req = 1'b1;
    observe(1'b0, lat, busy, rat, rpc, wm);
    irq_ext = 1'b0;
    chk("hold_mret_lat", lat, 1);
    chk("hold_mret_busy", busy, 4);
    chk("hold_mret_mstatus", mstatus_m, 32'h80);
    repeat (20) @(posedge clk);
    #1;

    // Simultaneous mret and external irq
    poke(12'h300, 32'h80); poke(12'h304, 32'h800); poke(12'h341, 32'h50); poke(12'h305, 32'h200);
    pc_cur = 32'h70; mret_req = 1'b1; irq_ext = 1'b1;
    observe(1'b0, lat, busy, rat, rpc, wm);
    chk("sim_mret_busy", busy, 4);
    chk("sim_mret_pc", rpc, 32'h50);
    chk("sim_mret_mstatus", mstatus_m, 32'h88);
    pc_cur = 32'h90;
    observe(1'b1, lat, busy, rat, rpc, wm);
    chk("sim_trap_lat", lat, 1);
    chk("sim_trap_busy", busy, 7);
    chk("sim_trap_pc", rpc, 32'h200);
    chk("sim_trap_mepc", mepc_m, 32'h90);
    chk("sim_trap_mstatus", mstatus_m, 32'h80);

    // Reset in T_EPC
    poke(12'h300, 32'h8);
    pc_cur = 32'hA0; irq_ext = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("epc_wr", 32'(bus.csr_wr), 32'd1);
    chk("epc_addr", 32'(bus.csr_addr), 32'h341);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(trap_busy), 32'd0);
    chk("arst_strobes", 32'({bus.csr_rd, bus.csr_wr, pc_redirect_valid}), 32'd0);
    chk("arst_addr", 32'(bus.csr_addr), 32'd0);
    chk("arst_wdata", bus.csr_wdata, 32'd0);
    chk("arst_pc", pc_redirect, 32'd0);
    irq_ext = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (trap_busy || bus.csr_rd || bus.csr_wr || pc_redirect_valid) act++;
    end
    $display("txn: reset abort, post-release activity=%0d mepc=0x%08h", act, mepc_m);
    chk("post_rst_idle", act, 0);
    chk("post_rst_mepc", mepc_m, 32'h90);

    chk("protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
